com_ctrl: RTL

COM_CTRL -- requirements
Module: com_ctrl

---
 rtl/com_ctrl.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/com_ctrl.sv
// Communication controller: TX FIFO with length-driven sender, RX FIFO with
// software pop, and a byte-wise CRC-16/CCITT engine, all driven by a cfg word.
module com_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [71:0] i_com_cfg,
    output logic [55:0] o_com_stat,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} tx_state_t;

    logic [7:0]  crc_en, crc_i1, crc_i2, wr_en, wr, wr_len, rd_en;
    logic [15:0] crc_init;

    assign crc_en   = i_com_cfg[7:0];
    assign crc_init = {i_com_cfg[23:16], i_com_cfg[15:8]};
    assign crc_i1   = i_com_cfg[31:24];
    assign crc_i2   = i_com_cfg[39:32];
    assign wr_en    = i_com_cfg[47:40];
    assign wr       = i_com_cfg[55:48];
    assign wr_len   = i_com_cfg[63:56];
    assign rd_en    = i_com_cfg[71:64];

    logic unused_cfg;
    assign unused_cfg = ^{crc_en[7:3], wr_en[7:2], wr_len[7:4], rd_en[7:2]};

    // Rising-edge detection on the level-held command bits.
    logic [6:0] cmd_cur, cmd_q, cmd_rise;
    logic [2:0] crc_rise;
    logic [1:0] wr_rise, rd_rise;

    assign cmd_cur  = {rd_en[1:0], wr_en[1:0], crc_en[2:0]};
    assign cmd_rise = cmd_cur & ~cmd_q;
    assign crc_rise = cmd_rise[2:0];
    assign wr_rise  = cmd_rise[4:3];
    assign rd_rise  = cmd_rise[6:5];

    always_ff @(posedge clk) begin
        if (rst) cmd_q <= '0;
        else     cmd_q <= cmd_cur;
    end

    // ---------------- TX path ----------------
    logic [7:0] tx_mem [8];
    logic [2:0] tx_wr, tx_rd;
    logic [3:0] tx_cnt, remaining, tx_len;
    tx_state_t  tx_state, tx_next;
    logic       tx_full, tx_pop, tx_push, tx_ovf_evt, len_ok, tx_busy;
    logic       wr_ovf, wr_done;

    assign tx_len     = wr_len[3:0];
    assign tx_full    = (tx_cnt == 4'd8);
    assign tx_busy    = (tx_state != IDLE);
    assign tx_pop     = (tx_state == SEND) && i_tx_ready;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign tx_push    = wr_rise[0] && (!tx_full || tx_pop);
    assign tx_ovf_evt = wr_rise[0] && tx_full && !tx_pop;
    assign len_ok     = (tx_len != 4'd0) && (tx_len <= 4'd8) && (tx_cnt >= tx_len);

    always_comb begin
        tx_next    = tx_state;
        o_tx_valid = 1'b0;
        o_tx_data  = 8'h00;
        case (tx_state)
            IDLE: if (len_ok) tx_next = SEND;
            SEND: begin
                o_tx_valid = 1'b1;
                o_tx_data  = tx_mem[tx_rd];
                if (i_tx_ready && remaining == 4'd1) tx_next = DONE;
            end
            DONE:    tx_next = IDLE;
            default: tx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state  <= IDLE;
            remaining <= '0;
        end else begin
            tx_state <= tx_next;
            if (tx_state == IDLE && len_ok) remaining <= tx_len;
            else if (tx_pop)                remaining <= remaining - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= wr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + 3'd1;
            if (tx_pop)  tx_rd <= tx_rd + 3'd1;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 4'd1;
                2'b01:   tx_cnt <= tx_cnt - 4'd1;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ovf  <= 1'b0;
            wr_done <= 1'b0;
        end else if (wr_rise[1]) begin
            wr_ovf  <= 1'b0;
            wr_done <= 1'b0;
        end else begin
            if (tx_ovf_evt) wr_ovf <= 1'b1;
            if (tx_state == DONE) wr_done <= 1'b1;
            else if (wr_rise[0])  wr_done <= 1'b0;
        end
    end

    // ---------------- RX path ----------------
    logic [7:0] rx_mem [8];
    logic [2:0] rx_wr, rx_rd;
    logic [3:0] rx_cnt;
    logic       rx_full, rx_push, rx_pop;
    logic [7:0] rd_data;
    logic       rd_valid, rd_unf;

    assign rx_full    = (rx_cnt == 4'd8);
    assign o_rx_ready = !rx_full;
    assign rx_push    = i_rx_valid && !rx_full;
    // Emptiness is judged before this cycle's push, so a same-cycle push cannot mask underflow.
    assign rx_pop     = rd_rise[0] && (rx_cnt != 4'd0);

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr] <= i_rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_cnt   <= '0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
            rd_unf   <= 1'b0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + 3'd1;
            if (rx_pop)  rx_rd <= rx_rd + 3'd1;
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 4'd1;
                2'b01:   rx_cnt <= rx_cnt - 4'd1;
                default: rx_cnt <= rx_cnt;
            endcase
            if (rd_rise[1]) begin
                rd_valid <= 1'b0;
                rd_unf   <= 1'b0;
            end
            if (rd_rise[0]) begin
                if (rx_cnt != 4'd0) begin
                    rd_data  <= rx_mem[rx_rd];
                    rd_valid <= 1'b1;
                end else begin
                    rd_unf   <= 1'b1;
                    rd_valid <= 1'b0;
                end
            end
        end
    end

    // ---------------- CRC engine ----------------
    logic [15:0] crc;
    logic        crc_busy, crc_two, crc_phase, crc_done;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            crc       <= 16'h0000;
            crc_busy  <= 1'b0;
            crc_two   <= 1'b0;
            crc_phase <= 1'b0;
            crc_done  <= 1'b0;
        end else if (crc_busy) begin
            crc <= crc_step(crc, crc_phase ? crc_i2 : crc_i1);
            if (crc_two && !crc_phase) begin
                crc_phase <= 1'b1;
            end else begin
                crc_phase <= 1'b0;
                crc_busy  <= 1'b0;
                crc_done  <= 1'b1;
            end
        end else if (crc_rise[0]) begin
            crc      <= crc_init;
            crc_done <= 1'b0;
        end else if (crc_rise[1] || crc_rise[2]) begin
            crc_busy  <= 1'b1;
            crc_two   <= crc_rise[1];
            crc_phase <= 1'b0;
            crc_done  <= 1'b0;
        end
    end

    assign o_com_stat = {
        4'b0, rx_cnt,
        5'b0, rx_full, rd_unf, rd_valid,
        rd_data,
        tx_cnt, wr_done, wr_ovf, tx_full, tx_busy,
        crc[15:8],
        crc[7:0],
        6'b0, crc_done, crc_busy
    };

endmodule
